// File: rtl/mem_if_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mem_if_pkg                                                   |
// | Description : Shared definitions for the RAM responder: read-FSM state     |
// |               encoding, word-index extraction constant and the layout of   |
// |               a posted-write FIFO entry ({idx, data}).                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package mem_if_pkg;

  // Width of one array word and of the request data lanes.
  localparam int DATA_W = 32;

  // Byte-address bits below the word index; addr[WORD_LSB-1:0] are ignored.
  localparam int WORD_LSB = 2;

  // Wait-state counter width, enough for a programmed latency of 0..15.
  localparam int LAT_W = 4;

  // Read FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_RD_ISSUE = 2'd2,
    ST_RD_DONE  = 2'd3
  } rd_state_t;

  // A FIFO entry packs the word index above the data word.
  function automatic int entry_width(input int idx_w);
    return idx_w + DATA_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_write_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_write_buffer                                             |
// | Description : Circular posted-write FIFO. Each entry is {idx, data}. The   |
// |               head entry is presented for draining into the array, and all |
// |               slots are exposed oldest-first for the read-forward compare. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, rst             clock, synchronous active-high reset (empties FIFO) |
// |   push, push_idx/data  append an entry (caller guarantees not full)        |
// |   pop                  drop the head entry (caller guarantees not empty)   |
// |   head_idx/head_data   oldest entry                                        |
// |   full, empty, count   occupancy                                           |
// |   age_idx/age_data     all slots packed oldest-first; slot k valid when    |
// |                        k < count                                           |
// +----------------------------------------------------------------------------+
module ram_write_buffer
  import mem_if_pkg::*;
#(
  parameter int IDX_W = 10,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [IDX_W-1:0]          push_idx,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  output logic [IDX_W-1:0]          head_idx,
  output logic [DATA_W-1:0]         head_data,
  output logic                      full,
  output logic                      empty,
  output logic [CNT_W-1:0]          count,
  output logic [DEPTH*IDX_W-1:0]    age_idx,
  output logic [DEPTH*DATA_W-1:0]   age_data
);

  localparam int ENT_W = entry_width(IDX_W);

  logic [ENT_W-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        store[wr_ptr] <= {push_idx, push_data};
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop && !push) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign full      = (cnt == CNT_W'(DEPTH));
  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign head_idx  = store[rd_ptr][ENT_W-1 -: IDX_W];
  assign head_data = store[rd_ptr][DATA_W-1:0];

  // Re-order the ring into age order so the consumer can pick the newest match
  // simply by scanning from low to high index.
  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    logic [PTR_W-1:0] slot;
    assign slot = rd_ptr + PTR_W'(k);
    assign age_idx[k*IDX_W +: IDX_W]    = store[slot][ENT_W-1 -: IDX_W];
    assign age_data[k*DATA_W +: DATA_W] = store[slot][DATA_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/ram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_responder                                                |
// | Description : Memory-side end of the RAM request lanes. Writes are posted  |
// |               into a small FIFO and drained into a single-port word array  |
// |               whenever a read is not using the port. Reads complete after  |
// |               RD_LAT wait states; ram_stall back-pressures the initiator.  |
// | Config      : RAM_RESP_FWD_EN defined   -> reads forward from posted       |
// |                                            writes, no read hazard stall    |
// |               RAM_RESP_FWD_EN undefined -> reads wait for an empty FIFO    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk          clock, all logic on posedge                                 |
// |   rst          synchronous active-high reset                               |
// |   ram_r        read request strobe, ram_r_addr its byte address            |
// |   ram_w        write request strobe, ram_w_addr/ram_w_line addr and data   |
// |   ram_r_line   registered read data, held until the next read completes   |
// |   ram_r_valid  one-cycle pulse when ram_r_line is updated                 |
// |   ram_stall    request not accepted this cycle (combinational)            |
// +----------------------------------------------------------------------------+
module ram_responder
  import mem_if_pkg::*;
#(
  parameter int AW       = 10,
  parameter int WB_DEPTH = 4,
  parameter int RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_r,
  input  logic [31:0] ram_r_addr,
  input  logic        ram_w,
  input  logic [31:0] ram_w_addr,
  input  logic [31:0] ram_w_line,
  output logic [31:0] ram_r_line,
  output logic        ram_r_valid,
  output logic        ram_stall
);

  localparam int CNT_W = $clog2(WB_DEPTH) + 1;
  // RD_WAIT runs RD_LAT cycles: it is entered with RD_LAT-1 and leaves at 0.
  localparam logic [LAT_W-1:0] WAIT_LOAD = (RD_LAT > 0) ? LAT_W'(RD_LAT - 1) : '0;

  logic [DATA_W-1:0] mem [2**AW];

  rd_state_t         state;
  logic [LAT_W-1:0]  wait_cnt;
  logic [AW-1:0]     rd_idx;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  // Set when the write half of a combined read+write request has already been
  // pushed while the read half is still stalled, so the held write is not
  // pushed twice and does not keep the read hazard alive.
  logic              w_taken;

  logic [AW-1:0]     r_idx;
  logic [AW-1:0]     w_idx;
  logic              idle;
  logic              w_new;
  logic              rd_hazard;
  logic              rd_accept;
  logic              cand_hit;
  logic [DATA_W-1:0] cand_data;

  logic                       wb_push;
  logic                       wb_pop;
  logic [AW-1:0]              wb_head_idx;
  logic [DATA_W-1:0]          wb_head_data;
  logic                       wb_full;
  logic                       wb_empty;
  logic [CNT_W-1:0]           wb_count;
  logic [WB_DEPTH*AW-1:0]     wb_age_idx;
  logic [WB_DEPTH*DATA_W-1:0] wb_age_data;

  // Word index; low byte-offset bits and bits above the array are ignored.
  assign r_idx = ram_r_addr[AW+WORD_LSB-1:WORD_LSB];
  assign w_idx = ram_w_addr[AW+WORD_LSB-1:WORD_LSB];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ram_r_addr[31:AW+WORD_LSB], ram_r_addr[WORD_LSB-1:0],
                              ram_w_addr[31:AW+WORD_LSB], ram_w_addr[WORD_LSB-1:0]};

  assign idle  = (state == ST_IDLE);
  assign w_new = ram_w & ~w_taken;

`ifdef RAM_RESP_FWD_EN
  assign rd_hazard = 1'b0;

  // Newest matching posted write wins; a same-cycle write is newer than any
  // FIFO entry, so it is checked last.
  always_comb begin
    cand_hit  = 1'b0;
    cand_data = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      if ((CNT_W'(k) < wb_count) && (wb_age_idx[k*AW +: AW] == r_idx)) begin
        cand_hit  = 1'b1;
        cand_data = wb_age_data[k*DATA_W +: DATA_W];
      end
    end
    if (wb_push && (w_idx == r_idx)) begin
      cand_hit  = 1'b1;
      cand_data = ram_w_line;
    end
  end
`else
  // Without forwarding a read only proceeds once every posted write, including
  // one arriving alongside it, has reached the array.
  assign rd_hazard = ram_r & (~wb_empty | w_new);
  assign cand_hit  = 1'b0;
  assign cand_data = '0;

  logic unused_fwd_bits;
  assign unused_fwd_bits = ^{wb_count, wb_age_idx, wb_age_data};
`endif

  assign ram_stall = ~idle | (w_new & wb_full) | rd_hazard;
  assign rd_accept = ram_r & ~ram_stall;
  // A write can be taken while only the read half stalls; it is ordered first.
  assign wb_push   = w_new & idle & ~wb_full;
  // The array port belongs to the read only in RD_ISSUE; reset discards the FIFO.
  assign wb_pop    = ~rst & ~wb_empty & (state != ST_RD_ISSUE);

  ram_write_buffer #(
    .IDX_W (AW),
    .DEPTH (WB_DEPTH)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (wb_push),
    .push_idx  (w_idx),
    .push_data (ram_w_line),
    .pop       (wb_pop),
    .head_idx  (wb_head_idx),
    .head_data (wb_head_data),
    .full      (wb_full),
    .empty     (wb_empty),
    .count     (wb_count),
    .age_idx   (wb_age_idx),
    .age_data  (wb_age_data)
  );

  // Array write side: background drain of the FIFO head. Contents survive reset.
  always_ff @(posedge clk) begin
    if (wb_pop) begin
      mem[wb_head_idx] <= wb_head_data;
    end
  end

  // Read FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      rd_idx      <= '0;
      fwd_hit     <= 1'b0;
      fwd_data    <= '0;
      w_taken     <= 1'b0;
      ram_r_line  <= '0;
      ram_r_valid <= 1'b0;
    end else begin
      ram_r_valid <= 1'b0;

      if (!ram_stall) begin
        w_taken <= 1'b0;
      end else if (wb_push) begin
        w_taken <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (rd_accept) begin
            rd_idx   <= r_idx;
            fwd_hit  <= cand_hit;
            fwd_data <= cand_data;
            wait_cnt <= WAIT_LOAD;
            state    <= (RD_LAT == 0) ? ST_RD_ISSUE : ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (wait_cnt == '0) begin
            state <= ST_RD_ISSUE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_RD_ISSUE: begin
          ram_r_line  <= fwd_hit ? fwd_data : mem[rd_idx];
          ram_r_valid <= 1'b1;
          state       <= ST_RD_DONE;
        end
        ST_RD_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
